network_controller: RTL and testbench

//  Sequencer directly upstream of the bitstream network. Accepts one sample per valid/ready handshake.

---
 rtl/network_pkg.sv | 38 +++
 rtl/argmax_select.sv | 43 ++++
 rtl/network_controller.sv | 124 ++++++++++++
 tb/tb_network_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/network_pkg.sv
// Shared types, defaults and helpers for the bitstream network sequencer.
package network_pkg;

    localparam int DEFAULT_STREAM_LENGTH = 256;
    localparam int DEFAULT_VALUE_WIDTH   = 8;
    localparam int SCORE_WIDTH           = 32;

    typedef logic signed [SCORE_WIDTH-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        WARMUP,
        RUN,
        CAPTURE,
        SAMPLE,
        DONE
    } ctrl_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A single-output network still needs a one-bit class port.
    function automatic int class_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic word_t clamp_value(input word_t value, input int value_width);
        word_t limit;
        limit = (word_t'(1) <<< value_width) - word_t'(1);
        if (value < 0)
            return '0;
        if (value > limit)
            return limit;
        return value;
    endfunction

endpackage

// File: rtl/argmax_select.sv
// Registered argmax over N signed scores; ties resolve to the lowest index.
module argmax_select
    import network_pkg::*;
#(
    parameter int N = 1,
    parameter int W = SCORE_WIDTH
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      en,
    input  logic signed [W-1:0]       scores [N],
    output logic [class_width(N)-1:0] index,
    output logic signed [W-1:0]       max_value
);

    localparam int IDX_W = class_width(N);

    logic [IDX_W-1:0]    best_idx;
    logic signed [W-1:0] best_val;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        best_idx = '0;
        best_val = scores[0];
        for (int i = 1; i < N; i++) begin
            if (scores[i] > best_val) begin
                best_idx = IDX_W'(i);
                best_val = scores[i];
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            index     <= '0;
            max_value <= '0;
        end else if (en) begin
            index     <= best_idx;
            max_value <= best_val;
        end
    end

endmodule

// File: rtl/network_controller.sv
// Sequencer feeding one held sample through a warm-up plus counted bitstream window,
// then capturing the network scores and their argmax behind a valid/ready port.
module network_controller
    import network_pkg::*;
#(
    parameter int INPUT_SIZE    = 2,
    parameter int OUTPUT_SIZE   = 1,
    parameter int VALUE_WIDTH   = DEFAULT_VALUE_WIDTH,
    parameter int WARMUP        = 16,
    parameter int STREAM_LENGTH = DEFAULT_STREAM_LENGTH
) (
    input  logic                                clk,
    input  logic                                n_rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  word_t                               sample_in      [INPUT_SIZE],
    input  logic                                abort,
    output word_t                               network_input  [INPUT_SIZE],
    output logic                                compute,
    input  word_t                               network_output [OUTPUT_SIZE],
    output logic                                out_valid,
    input  logic                                out_ready,
    output word_t                               result_scores  [OUTPUT_SIZE],
    output logic [class_width(OUTPUT_SIZE)-1:0] result_class,
    output logic                                busy
);

    localparam int CNT_W = $clog2(max_int(WARMUP, STREAM_LENGTH) + 1);
    localparam logic [CNT_W-1:0] WARMUP_LAST = CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(STREAM_LENGTH - 1);

    ctrl_state_t state;
    ctrl_state_t next_state;
    logic [CNT_W-1:0] count;
    logic  load_en;
    logic  sample_en;
    word_t result_max;

    assign load_en   = (state == IDLE) && in_valid && !abort;
    assign sample_en = (state == SAMPLE) && !abort;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:             if (load_en) next_state = (WARMUP == 0) ? RUN : network_pkg::WARMUP;
            network_pkg::WARMUP:
                if (abort)                     next_state = IDLE;
                else if (count == WARMUP_LAST) next_state = RUN;
            RUN:
                if (abort)                  next_state = IDLE;
                else if (count == RUN_LAST) next_state = CAPTURE;
            CAPTURE:          next_state = abort ? IDLE : SAMPLE;
            SAMPLE:           next_state = abort ? IDLE : DONE;
            DONE:             if (abort || out_ready) next_state = IDLE;
            default:          next_state = IDLE;
        endcase
    end

    // An abort in CAPTURE suppresses the strobe so the integrators never latch a cut window.
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        compute   = (state == CAPTURE) && !abort;
        out_valid = (state == DONE);
    end

    // Any state change, including an abort, restarts the window count.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            count <= '0;
        else if (next_state != state)
            count <= '0;
        else if (state == network_pkg::WARMUP || state == RUN)
            count <= count + 1'b1;
    end

    // NOTE: these register arrays are reset element by element; they drive outputs with defined reset values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < INPUT_SIZE; i++)
                network_input[i] <= '0;
        end else if (load_en) begin
            for (int i = 0; i < INPUT_SIZE; i++)
                network_input[i] <= clamp_value(sample_in[i], VALUE_WIDTH);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int j = 0; j < OUTPUT_SIZE; j++)
                result_scores[j] <= '0;
        end else if (sample_en) begin
            for (int j = 0; j < OUTPUT_SIZE; j++)
                result_scores[j] <= network_output[j];
        end
    end

    argmax_select #(
        .N (OUTPUT_SIZE),
        .W (SCORE_WIDTH)
    ) u_argmax (
        .clk       (clk),
        .n_rst     (n_rst),
        .en        (sample_en),
        .scores    (network_output),
        .index     (result_class),
        .max_value (result_max)
    );

    // The registered maximum must be the score the registered class points at.
    always_comb begin
        if (state == DONE)
            assert (result_max == result_scores[result_class]);
    end

endmodule

// File: tb/tb_network_controller.sv
// Randomized bench for network_controller: a timeline model of each accepted job, plus directed cases.
module tb_network_controller;
    import network_pkg::*;

    localparam int IN_N  = 2;
    localparam int OUT_N = 3;
    localparam int VW    = 8;
    localparam int SL    = 8;
    localparam int WU [2] = '{4, 0};

    logic clk = 1'b0;
    logic n_rst = 1'b1;
    logic in_valid = 1'b0;
    logic abort = 1'b0;
    logic out_ready = 1'b0;
    word_t sample_in [IN_N];
    word_t net_out [OUT_N];

    logic ir0, cp0, ov0, bz0, ir1, cp1, ov1, bz1;
    word_t ni0 [IN_N];
    word_t ni1 [IN_N];
    word_t rs0 [OUT_N];
    word_t rs1 [OUT_N];
    logic [1:0] rc0, rc1;

    int n_checks = 0;
    int n_pass = 0;

    network_controller #(
        .INPUT_SIZE(IN_N), .OUTPUT_SIZE(OUT_N), .VALUE_WIDTH(VW), .WARMUP(4), .STREAM_LENGTH(SL)
    ) dut (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(ir0), .sample_in(sample_in),
        .abort(abort), .network_input(ni0), .compute(cp0), .network_output(net_out),
        .out_valid(ov0), .out_ready(out_ready), .result_scores(rs0), .result_class(rc0), .busy(bz0)
    );

    network_controller #(
        .INPUT_SIZE(IN_N), .OUTPUT_SIZE(OUT_N), .VALUE_WIDTH(VW), .WARMUP(0), .STREAM_LENGTH(SL)
    ) dut_nowarm (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(ir1), .sample_in(sample_in),
        .abort(abort), .network_input(ni1), .compute(cp1), .network_output(net_out),
        .out_valid(ov1), .out_ready(out_ready), .result_scores(rs1), .result_class(rc1), .busy(bz1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual == expected)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rules: clamp into the probability scale, argmax = first index holding the maximum.
    function automatic int ref_clamp(input int v);
        int top;
        top = (1 << VW) - 1;
        return (v < 0) ? 0 : ((v > top) ? top : v);
    endfunction

    function automatic int ref_argmax(input word_t s [OUT_N]);
        int best;
        best = s[0];
        for (int j = 1; j < OUT_N; j++)
            if (s[j] > best) best = s[j];
        for (int j = 0; j < OUT_N; j++)
            if (s[j] == best) return j;
        return 0;
    endfunction

    // Model: a job lives from its accept edge; el counts edges since acceptance.
    bit job [2];
    int el [2];
    int exp_ni [2][IN_N];
    int exp_rs [2][OUT_N];
    int exp_rc [2];

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < 2; k++) begin
                job[k] <= 1'b0;
                el[k] <= 0;
                exp_rc[k] <= 0;
                for (int i = 0; i < IN_N; i++) exp_ni[k][i] <= 0;
                for (int j = 0; j < OUT_N; j++) exp_rs[k][j] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!job[k]) begin
                    if (in_valid && !abort) begin
                        job[k] <= 1'b1;
                        el[k] <= 0;
                        for (int i = 0; i < IN_N; i++) exp_ni[k][i] <= ref_clamp(sample_in[i]);
                    end
                end else if (abort || (el[k] >= WU[k] + SL + 2 && out_ready)) begin
                    job[k] <= 1'b0;
                end else begin
                    if (el[k] == WU[k] + SL + 1) begin
                        for (int j = 0; j < OUT_N; j++) exp_rs[k][j] <= net_out[j];
                        exp_rc[k] <= ref_argmax(net_out);
                    end
                    el[k] <= el[k] + 1;
                end
            end
        end
    end

    task automatic compare_unit(input int k, input logic ir, input logic bz, input logic cp,
                                input logic ov, input word_t ni [IN_N], input word_t rs [OUT_N],
                                input logic [1:0] rc);
        check($sformatf("u%0d_in_ready", k), ir, !job[k]);
        check($sformatf("u%0d_busy", k), bz, job[k]);
        check($sformatf("u%0d_compute", k), cp, job[k] && el[k] == WU[k] + SL && !abort);
        check($sformatf("u%0d_out_valid", k), ov, job[k] && el[k] >= WU[k] + SL + 2);
        for (int i = 0; i < IN_N; i++)
            check($sformatf("u%0d_network_input%0d", k, i), ni[i], exp_ni[k][i]);
        for (int j = 0; j < OUT_N; j++)
            check($sformatf("u%0d_result_scores%0d", k, j), rs[j], exp_rs[k][j]);
        check($sformatf("u%0d_result_class", k), rc, exp_rc[k]);
    endtask

    always @(negedge clk) begin
        compare_unit(0, ir0, bz0, cp0, ov0, ni0, rs0, rc0);
        compare_unit(1, ir1, bz1, cp1, ov1, ni1, rs1, rc1);
    end

    initial begin
        int n;
        int stable;
        for (int i = 0; i < IN_N; i++) sample_in[i] = '0;
        for (int j = 0; j < OUT_N; j++) net_out[j] = '0;
        #1 n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bz0, 0);
        check("rst_out_valid", ov0, 0);
        check("rst_compute", cp0, 0);
        check("rst_in_ready", ir0, 1);
        check("rst_network_input", ni0[1], 0);
        check("rst_result_class", rc0, 0);
        n_rst = 1'b1;
        tick();

        // Nominal sample, tied top scores resolve to the lower index.
        net_out = '{40, 90, 90};
        sample_in = '{100, 200};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("load_network_input0", ni0[0], 100);
        check("load_network_input1", ni0[1], 200);
        n = 0;
        while (!cp0 && n < 100) begin tick(); n++; end
        check("compute_latency", n, 12);
        while (!ov0 && n < 100) begin tick(); n++; end
        check("out_valid_latency", n, 14);
        check("tie_scores0", rs0[0], 40);
        check("tie_scores2", rs0[2], 90);
        check("tie_class", rc0, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_in_ready", ir0, 1);

        // Clamping, then backpressure with a pending result.
        sample_in = '{-5, 300};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("clamp_low", ni0[0], 0);
        check("clamp_high", ni0[1], 255);
        net_out = '{7, 3, 1};
        n = 0;
        while (!ov0 && n < 100) begin tick(); n++; end
        check("second_latency", n, 14);
        check("first_class", rc0, 0);
        stable = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            for (int i = 0; i < IN_N; i++) sample_in[i] = word_t'($urandom_range(0, 255));
            for (int j = 0; j < OUT_N; j++) net_out[j] = word_t'($urandom_range(0, 99));
            tick();
            if (ov0 && !ir0 && rc0 == 0 && rs0[0] == 7 && rs0[1] == 3 && ni0[1] == 255) stable++;
        end
        check("backpressure_stable_cycles", stable, 20);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("backpressure_release", ir0, 1);

        // Abort in RUN at counter 3.
        sample_in = '{10, 20};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_in_ready", ir0, 1);
        stable = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (cp0 || ov0) stable++;
        end
        check("abort_no_pulses", stable, 0);
        sample_in = '{33, 44};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!ov0 && n < 100) begin tick(); n++; end
        check("after_abort_latency", n, 14);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset in RUN, then a run without warm-up.
        sample_in = '{1, 2};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        #2 n_rst = 1'b0;
        #1;
        check("async_rst_busy", bz0, 0);
        check("async_rst_in_ready", ir0, 1);
        check("async_rst_network_input", ni0[0], 0);
        check("async_rst_scores", rs0[0], 0);
        @(posedge clk);
        #1 n_rst = 1'b1;
        sample_in = '{50, 60};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!ov1 && n < 100) begin tick(); n++; end
        check("nowarm_latency", n, 10);
        check("nowarm_network_input", ni1[1], 60);
        while (!ov0 && n < 100) begin tick(); n++; end
        check("warm_latency_after_reset", n, 14);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Random traffic with low-rate aborts and frequent score ties.
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            abort = ($urandom_range(0, 49) == 0);
            out_ready = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < IN_N; i++) sample_in[i] = word_t'(int'($urandom_range(0, 450)) - 50);
            for (int j = 0; j < OUT_N; j++) net_out[j] = word_t'($urandom_range(0, 6));
            tick();
        end
        in_valid = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
